// File: rtl/int_vector_gen_pkg.sv
// int_vector_gen_pkg: state encodings, vector constants and RST target helper for int_vector_gen.
package int_vector_gen_pkg;
  typedef enum logic [1:0] {
    IV_IDLE = 2'd0,
    IV_ACK  = 2'd1,
    IV_DONE = 2'd2
  } iv_state_t;
  localparam logic [15:0] NMI_VEC = 16'h0066;
  localparam logic [15:0] IM1_VEC = 16'h0038;
  localparam logic [7:0] IV_TMO_MAX = 8'd255;
  function automatic logic [7:0] rst_vec(input logic [7:0] d);
    return d & 8'h38;
  endfunction
endpackage

// File: rtl/int_vector_gen_nmi_edge.sv
// nmi_edge: rising-edge detector on nmi_in with a pending latch; a new edge beats clr.
module nmi_edge (
  input  logic clkc,
  input  logic resetb,
  input  logic nmi_in,
  input  logic clr,
  output logic nmi_pend
);
  logic nmi_d;
  always_ff @(posedge clkc or negedge resetb) begin
    if (!resetb) begin
      nmi_d <= 1'b0;
      nmi_pend <= 1'b0;
    end else begin
      nmi_d <= nmi_in;
      nmi_pend <= (nmi_in & ~nmi_d) | (nmi_pend & ~clr);
    end
  end
endmodule

// File: rtl/int_vector_gen.sv
// int_vector_gen: NMI/INT acknowledge sequencer and RST vector latch for the y80e core.
// Optional INT_ACK_TMO_EN adds a 255-cycle acknowledge timeout that falls back to the IM1 vector.
module int_vector_gen
  import int_vector_gen_pkg::*;
(
  input  logic        clkc,
  input  logic        resetb,
  input  logic        ins_end,
  input  logic        nmi_in,
  input  logic        int_in,
  input  logic        iff1,
  input  logic [1:0]  im_mode,
  input  logic        inta_strb,
  input  logic [7:0]  din,
  input  logic [7:0]  ii_reg,
  input  logic        rst_ld,
  output logic [15:0] int_addr,
  output logic [7:0]  rst_addr,
  output logic        inta_cyc,
  output logic        vec_vld,
  output logic        nmi_svc,
  output logic        int_svc
);
  iv_state_t state, state_nx;
  logic [15:0] int_addr_nx;
  logic [7:0] rst_addr_nx;
  logic inta_cyc_nx, vec_vld_nx, nmi_svc_nx, int_svc_nx;
  logic nmi_pend, nmi_take, tmo_hit;

  nmi_edge u_nmi (
    .clkc(clkc),
    .resetb(resetb),
    .nmi_in(nmi_in),
    .clr(nmi_take),
    .nmi_pend(nmi_pend)
  );

`ifdef INT_ACK_TMO_EN
  logic [7:0] tmo_cnt;
  // Held at zero outside ACK, so it restarts from zero on every ACK entry.
  always_ff @(posedge clkc or negedge resetb) begin
    if (!resetb) tmo_cnt <= 8'd0;
    else tmo_cnt <= (state == IV_ACK) ? tmo_cnt + 8'd1 : 8'd0;
  end
  assign tmo_hit = (state == IV_ACK) && (tmo_cnt == IV_TMO_MAX);
`else
  assign tmo_hit = 1'b0;
`endif

  assign nmi_take = (state == IV_IDLE) && ins_end && nmi_pend;

  always_comb begin
    state_nx = state;
    int_addr_nx = int_addr;
    rst_addr_nx = rst_ld ? rst_vec(din) : rst_addr;
    inta_cyc_nx = 1'b0;
    vec_vld_nx = 1'b0;
    nmi_svc_nx = 1'b0;
    int_svc_nx = 1'b0;
    case (state)
      IV_IDLE: begin
        if (nmi_take) begin
          int_addr_nx = NMI_VEC;
          nmi_svc_nx = 1'b1;
          state_nx = IV_DONE;
        end else if (ins_end && int_in && iff1) begin
          inta_cyc_nx = 1'b1;
          state_nx = IV_ACK;
        end
      end
      IV_ACK: begin
        inta_cyc_nx = 1'b1;
        if (inta_strb) begin
          // Capture cycle: rst_ld is overridden, only mode 0 touches rst_addr.
          int_addr_nx = (im_mode == 2'd2) ? {ii_reg, din & 8'hFE} :
                        (im_mode == 2'd0) ? {8'h00, rst_vec(din)} : IM1_VEC;
          rst_addr_nx = (im_mode == 2'd0) ? rst_vec(din) : rst_addr;
          inta_cyc_nx = 1'b0;
          int_svc_nx = 1'b1;
          state_nx = IV_DONE;
        end else if (tmo_hit) begin
          int_addr_nx = IM1_VEC;
          inta_cyc_nx = 1'b0;
          int_svc_nx = 1'b1;
          state_nx = IV_DONE;
        end
      end
      IV_DONE: begin
        vec_vld_nx = 1'b1;
        state_nx = IV_IDLE;
      end
      default: state_nx = IV_IDLE;
    endcase
  end

  always_ff @(posedge clkc or negedge resetb) begin
    if (!resetb) begin
      state <= IV_IDLE;
      int_addr <= 16'h0000;
      rst_addr <= 8'h00;
      inta_cyc <= 1'b0;
      vec_vld <= 1'b0;
      nmi_svc <= 1'b0;
      int_svc <= 1'b0;
    end else begin
      state <= state_nx;
      int_addr <= int_addr_nx;
      rst_addr <= rst_addr_nx;
      inta_cyc <= inta_cyc_nx;
      vec_vld <= vec_vld_nx;
      nmi_svc <= nmi_svc_nx;
      int_svc <= int_svc_nx;
    end
  end
endmodule

// File: tb/tb_int_vector_gen.sv
// tb_int_vector_gen: directed bench for int_vector_gen with a cycle model checked on every falling edge.
module tb_int_vector_gen;
  logic clkc = 1'b0, resetb = 1'b0, ins_end = 1'b0, nmi_in = 1'b0, int_in = 1'b0, iff1 = 1'b0;
  logic [1:0] im_mode = 2'd0;
  logic inta_strb = 1'b0, rst_ld = 1'b0;
  logic [7:0] din = 8'h00, ii_reg = 8'h00;
  logic [15:0] int_addr;
  logic [7:0] rst_addr;
  logic inta_cyc, vec_vld, nmi_svc, int_svc;
  int checks = 0, failures = 0;

  int_vector_gen dut (
    .clkc(clkc), .resetb(resetb), .ins_end(ins_end), .nmi_in(nmi_in), .int_in(int_in),
    .iff1(iff1), .im_mode(im_mode), .inta_strb(inta_strb), .din(din), .ii_reg(ii_reg),
    .rst_ld(rst_ld), .int_addr(int_addr), .rst_addr(rst_addr), .inta_cyc(inta_cyc),
    .vec_vld(vec_vld), .nmi_svc(nmi_svc), .int_svc(int_svc)
  );

  always #5 clkc = ~clkc;

  task automatic cmp(input string n, input logic [15:0] a, input logic [15:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask

  // Model: vec_vld follows any service pulse by one cycle; boundaries are ignored while
  // acknowledging or while a service pulse is out.
  bit [15:0] e_int_addr;
  bit [7:0] e_rst_addr;
  bit e_inta_cyc, e_vec_vld, e_nmi_svc, e_int_svc;
  bit m_ack, m_pend, m_prev, was_svc, idle, cap, take;
  int m_wait;

  always @(posedge clkc or negedge resetb) begin
    if (!resetb) begin
      e_int_addr = 0; e_rst_addr = 0; e_inta_cyc = 0; e_vec_vld = 0; e_nmi_svc = 0; e_int_svc = 0;
      m_ack = 0; m_pend = 0; m_prev = 0; m_wait = 0;
    end else begin
      was_svc = e_nmi_svc | e_int_svc;
      idle = !m_ack && !was_svc;
      e_vec_vld = was_svc; e_nmi_svc = 0; e_int_svc = 0; cap = 0; take = 0;
      if (idle && ins_end && m_pend) begin
        take = 1; e_nmi_svc = 1; e_int_addr = 16'h0066;
      end else if (idle && ins_end && int_in && iff1) begin
        m_ack = 1; m_wait = 0;
      end else if (m_ack && inta_strb) begin
        cap = 1; m_ack = 0; e_int_svc = 1;
        if (im_mode == 2) e_int_addr = {ii_reg, din[7:1], 1'b0};
        else if (im_mode == 0) begin
          e_rst_addr = {2'b00, din[5:3], 3'b000};
          e_int_addr = {8'h00, e_rst_addr};
        end else e_int_addr = 16'h0038;
      end else if (m_ack) begin
`ifdef INT_ACK_TMO_EN
        if (m_wait == 255) begin
          m_ack = 0; e_int_svc = 1; e_int_addr = 16'h0038;
        end else m_wait++;
`endif
      end
      if (rst_ld && !cap) e_rst_addr = {2'b00, din[5:3], 3'b000};
      m_pend = (nmi_in && !m_prev) || (m_pend && !take);
      m_prev = nmi_in;
      e_inta_cyc = m_ack;
    end
  end

  always @(negedge clkc) begin
    cmp("m_int_addr", int_addr, e_int_addr);
    cmp("m_rst_addr", {8'h00, rst_addr}, {8'h00, e_rst_addr});
    cmp("m_inta_cyc", {15'h0, inta_cyc}, {15'h0, e_inta_cyc});
    cmp("m_vec_vld", {15'h0, vec_vld}, {15'h0, e_vec_vld});
    cmp("m_nmi_svc", {15'h0, nmi_svc}, {15'h0, e_nmi_svc});
    cmp("m_int_svc", {15'h0, int_svc}, {15'h0, e_int_svc});
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clkc); #1; end
  endtask
  task automatic pulse_ins();
    ins_end = 1; tick(); ins_end = 0;
  endtask
  task automatic strobe(input logic [7:0] d, input logic rl = 1'b0);
    din = d; rst_ld = rl; inta_strb = 1; tick(); inta_strb = 0; rst_ld = 0;
  endtask
  task automatic enter_ack(input logic [1:0] m, input logic [7:0] ii);
    iff1 = 1; int_in = 1; im_mode = m; ii_reg = ii; pulse_ins(); int_in = 0;
  endtask
  task automatic nmi_pulse();
    nmi_in = 1; tick(); nmi_in = 0;
  endtask
  task automatic chk_zero(input string n);
    cmp({n, "_addr"}, int_addr, 16'h0000);
    cmp({n, "_rst"}, {8'h00, rst_addr}, 16'h0000);
    cmp({n, "_flags"}, {12'h0, inta_cyc, vec_vld, nmi_svc, int_svc}, 16'h0000);
  endtask

  initial begin
    tick(3);
    chk_zero("reset");
    resetb = 1; tick();
    // NMI path
    nmi_pulse(); tick();
    pulse_ins();
    cmp("nmi_svc", {15'h0, nmi_svc}, 16'h1);
    cmp("nmi_addr", int_addr, 16'h0066);
    tick();
    cmp("nmi_vld", {14'h0, vec_vld, nmi_svc}, 16'h2);
    tick(); pulse_ins();
    cmp("nmi_cleared", {15'h0, nmi_svc}, 16'h0);
    tick();
    // IM0 with coincident rst_ld: capture value wins
    enter_ack(2'd0, 8'h00);
    cmp("im0_inta", {15'h0, inta_cyc}, 16'h1);
    tick(2);
    strobe(8'hEF, 1'b1);
    cmp("im0_rst", {8'h00, rst_addr}, 16'h0028);
    cmp("im0_addr", int_addr, 16'h0028);
    cmp("im0_svc", {14'h0, int_svc, inta_cyc}, 16'h2);
    tick();
    cmp("im0_vld", {15'h0, vec_vld}, 16'h1);
    tick();
    // IM2 capture, rst_ld during capture ignored
    enter_ack(2'd2, 8'h80);
    tick(3);
    strobe(8'h25, 1'b1);
    cmp("im2_addr", int_addr, 16'h8024);
    cmp("im2_rst_kept", {8'h00, rst_addr}, 16'h0028);
    tick(2);
    // rst_ld in IDLE
    din = 8'hFF; rst_ld = 1; tick(); rst_ld = 0;
    cmp("rst_ld_idle", {8'h00, rst_addr}, 16'h0038);
    // IM1 and mode 3
    enter_ack(2'd1, 8'h55); strobe(8'hAA);
    cmp("im1_addr", int_addr, 16'h0038);
    tick(2);
    enter_ack(2'd2, 8'h55); im_mode = 2'd3; strobe(8'hAA);
    cmp("im3_addr", int_addr, 16'h0038);
    tick(2);
    // NMI beats INT at the same boundary, INT taken at the next one
    nmi_pulse(); iff1 = 1; int_in = 1; im_mode = 2'd2; ii_reg = 8'hC3;
    pulse_ins();
    cmp("prio_nmi", {14'h0, nmi_svc, inta_cyc}, 16'h2);
    tick(); pulse_ins();
    cmp("prio_int", {15'h0, inta_cyc}, 16'h1);
    int_in = 0; strobe(8'h7F);
    cmp("prio_addr", int_addr, 16'hC37E);
    tick(2);
    // masked INT
    iff1 = 0; int_in = 1; pulse_ins(); tick();
    cmp("masked", {15'h0, inta_cyc}, 16'h0);
    int_in = 0; tick();
    // NMI edge and boundary during ACK
    enter_ack(2'd2, 8'h12);
    nmi_pulse(); pulse_ins();
    cmp("ack_no_nmi", {14'h0, nmi_svc, inta_cyc}, 16'h1);
    strobe(8'h44);
    cmp("ack_addr", int_addr, 16'h1244);
    tick(); pulse_ins();
    cmp("nmi_after_ack", {15'h0, nmi_svc}, 16'h1);
    cmp("nmi_after_addr", int_addr, 16'h0066);
    tick(2);
    // long wait in ACK: timeout fallback or indefinite hold
    enter_ack(2'd2, 8'h99);
`ifdef INT_ACK_TMO_EN
    begin
      int n = 0;
      while (!int_svc && n < 400) begin tick(); n++; end
      cmp("tmo_seen", {15'h0, int_svc}, 16'h1);
      cmp("tmo_addr", int_addr, 16'h0038);
    end
    tick(2);
`else
    tick(300);
    cmp("no_tmo", {15'h0, inta_cyc}, 16'h1);
    strobe(8'h01);
    cmp("late_addr", int_addr, 16'h9900);
    tick(2);
`endif
    // reset mid-ACK
    enter_ack(2'd0, 8'h00); tick(2);
    resetb = 0; #1;
    chk_zero("rst_ack");
    tick(); resetb = 1; tick(2);
    chk_zero("post_rst");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/int_vector_gen.md
# int_vector_gen

Interrupt and restart vector generator for the y80e core. Detects NMI edges, samples the maskable interrupt at instruction boundaries, runs the interrupt-acknowledge sequence for modes 0/1/2 and latches the RST target from decoded opcodes. It drives the `int_addr` and `rst_addr` buses consumed by the ALU A-input multiplexer, which loads them into the PC path.

## Interface
- No parameters; vector constants live in the shared define header.
- `clkc`  in  1  core clock; all state updates on rising edge
- `resetb`  in  1  asynchronous, active-low reset
- `ins_end`  in  1  one-cycle pulse at the instruction boundary
- `nmi_in`  in  1  NMI request, already synchronised to `clkc`
- `int_in`  in  1  maskable interrupt request, level
- `iff1`  in  1  interrupt enable flip-flop
- `im_mode`  in  2  interrupt mode: 0, 1, 2 (3 treated as 1)
- `inta_strb`  in  1  acknowledge-cycle data-valid strobe
- `din`  in  8  data bus input
- `ii_reg`  in  8  I register
- `rst_ld`  in  1  decoder strobe: RST opcode present on `din`
- `int_addr`  out  16  interrupt target address
- `rst_addr`  out  8  restart address
- `inta_cyc`  out  1  high while the acknowledge cycle is awaiting `inta_strb`
- `vec_vld`  out  1  one-cycle pulse: `int_addr` valid
- `nmi_svc`  out  1  one-cycle pulse: NMI taken (control clears IFF1 only)
- `int_svc`  out  1  one-cycle pulse: maskable interrupt taken (control clears IFF1/IFF2)

## Operation
- States: IDLE, ACK, DONE.
- NMI latch: rising edge of `nmi_in` sets `nmi_pend`. The latch clears in the cycle the NMI is taken. An edge arriving in the same cycle as the take re-sets the latch (set wins).
- IDLE, on `ins_end`:
  - if `nmi_pend`: `int_addr`=16'h0066, `nmi_svc`=1, go to DONE;
  - else if `int_in & iff1`: `inta_cyc`=1, go to ACK;
  - otherwise remain in IDLE.
- NMI has priority over INT in the same cycle.
- ACK, on `inta_strb`, `din` is captured:
  - mode 1/3: `int_addr`=16'h0038;
  - mode 2: `int_addr`={`ii_reg`, `din`[7:1], 1'b0};
  - mode 0: `rst_addr`={2'b00, `din`[5:3], 3'b000} and `int_addr`={8'h00, that value}.
  - In all modes: `int_svc`=1, then go to DONE.
- ACK ignores `ins_end` and new NMI edges. A pending NMI is serviced at the next boundary after DONE.
- DONE: `vec_vld`=1 for exactly one cycle, then return to IDLE.
- `rst_ld` (any state except the ACK capture cycle): `rst_addr`={2'b00, `din`[5:3], 3'b000}. If `rst_ld` and the ACK capture coincide, the ACK capture wins and `rst_ld` is ignored.
- `int_addr` and `rst_addr` hold their values until the next update.

## Timing
- All outputs are registered.
- Reset values: state=IDLE, `int_addr`=16'h0000, `rst_addr`=8'h00, `inta_cyc`=0, `vec_vld`=0, `nmi_svc`=0, `int_svc`=0, `nmi_pend`=0.
- NMI path: `ins_end` in cycle n → `nmi_svc` in n+1 → `vec_vld` in n+2.
- INT path: `ins_end` in cycle n → `inta_cyc` from n+1 until the strobe; `inta_strb` in cycle m → `int_addr`/`int_svc` in m+1 → `vec_vld` in m+2.
- `inta_cyc` drops in the same edge that asserts `int_svc`.
- `int_in` or `iff1` falling while in ACK does not abort the sequence.
- `resetb` low at any time, including mid-ACK: immediate return to the reset values.

## Configuration
- `INT_ACK_TMO_EN` defined:
  - an 8-bit counter runs while in ACK;
  - if 255 cycles elapse with no `inta_strb`, the block forces `int_addr`=16'h0038 and `int_svc`=1, then goes to DONE;
  - the counter clears on entry to ACK and on reset.
- `INT_ACK_TMO_EN` undefined: ACK waits indefinitely and no counter logic is present.

## Structure
- Shared define header holds:
  - state encodings `IV_IDLE`, `IV_ACK`, `IV_DONE`;
  - `NMI_VEC`=16'h0066 and `IM1_VEC`=16'h0038;
  - `IV_TMO_MAX`=8'd255.
- One sub-module: `nmi_edge`, the rising-edge detector with set-priority pending latch and clear input.
- The state machine and vector muxing stay in the top module.

## Test plan
- NMI: pulse `nmi_in`, then `ins_end` → `nmi_svc` next cycle, `int_addr`=16'h0066, `vec_vld` one cycle later; `nmi_pend` cleared.
- IM2: `iff1`=1, `int_in`=1, `im_mode`=2, `ii_reg`=8'h80, `ins_end`, then `inta_strb` with `din`=8'h25 → `int_addr`=16'h8024, `int_svc`=1, then `vec_vld`.
- IM0: `din`=8'hEF (RST 28h) on strobe → `rst_addr`=8'h28, `int_addr`=16'h0028. IM1 or `im_mode`=3 → `int_addr`=16'h0038.
- Priority and masking:
  - NMI pending plus `int_in` at the same `ins_end` → NMI taken first;
  - `iff1`=0 with `int_in` → no acknowledge (`inta_cyc` stays low).
- Concurrency:
  - `rst_ld` with `din`=8'hFF in IDLE → `rst_addr`=8'h38;
  - `rst_ld` coincident with the IM0 capture → the ACK value wins;
  - NMI edge during ACK → serviced at the next `ins_end`.
- Reset and timeout:
  - `resetb` low mid-ACK → IDLE and all outputs zero;
  - with `INT_ACK_TMO_EN`, no strobe for 255 cycles → `int_addr`=16'h0038 and `int_svc`=1.
